// File: rtl/scan_test_controller.sv
// Scan-chain test controller: shifts {pat_a,pat_b} into a chain, captures one cycle,
// shifts the product back out and compares it against pat_a*pat_b.
module scan_test_controller #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   pat_a,
   input  logic [N-1:0]   pat_b,
   input  logic           scan_out,
   output logic           scan_in,
   output logic           scan_en,
   output logic           busy,
   output logic           done,
   output logic           pass,
   output logic [2*N-1:0] result,
   output logic [7:0]     err_cnt
);

   localparam int W  = 2 * N;
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} state_t;

   state_t         state;
   logic [W-1:0]   pat_q;
   logic [W-1:0]   expected;
   logic [W-1:0]   cap;
   logic [W-1:0]   final_res;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_nx;

   assign cnt_nx = cnt + CW'(1);

   // Last sampled bit merged in so result/pass land on the same edge as the sample.
   always_comb begin
      final_res      = cap;
      final_res[cnt] = scan_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         scan_in  <= 1'b0;
         scan_en  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         result   <= '0;
         err_cnt  <= '0;
         cnt      <= '0;
         pat_q    <= '0;
         expected <= '0;
         cap      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               scan_en <= 1'b0;
               scan_in <= 1'b0;
               cnt     <= '0;
               if (start) begin
                  pat_q    <= {pat_a, pat_b};
                  expected <= {{N{1'b0}}, pat_a} * {{N{1'b0}}, pat_b};
                  scan_in  <= pat_b[0];
                  scan_en  <= 1'b1;
                  busy     <= 1'b1;
                  state    <= SHIFT_IN;
               end
            end
            SHIFT_IN: begin
               if (cnt == LAST) begin
                  cnt     <= '0;
                  scan_en <= 1'b0;
                  scan_in <= 1'b0;
                  state   <= CAPTURE;
               end else begin
                  cnt     <= cnt_nx;
                  scan_in <= pat_q[cnt_nx];
               end
            end
            CAPTURE: begin
               cnt     <= '0;
               scan_en <= 1'b1;
               scan_in <= 1'b0;
               state   <= SHIFT_OUT;
            end
            SHIFT_OUT: begin
               cap[cnt] <= scan_out;
               if (cnt == LAST) begin
                  cnt     <= '0;
                  result  <= final_res;
                  pass    <= (final_res == expected);
                  if (final_res != expected && err_cnt != 8'hFF)
                     err_cnt <= err_cnt + 8'd1;
                  scan_en <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt <= cnt_nx;
               end
            end
            DONE: begin
               cnt   <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
